// File: rtl/m_alu_arbiter.sv
// m_alu_arbiter: round-robin arbiter sharing one external 8-bit ALU between two requesters.
// Latency: gnt the cycle after the IDLE sampling edge, done one cycle later; one operation per 3 cycles.
// Backpressure: requests are sampled only in IDLE and losers keep req high. Owner lock is built with ALU_ARB_LOCK_EN.
module m_alu_arbiter (
  input  logic       w_clock,
  input  logic       w_reset_n,
  input  logic       w_req0,
  input  logic       w_req1,
  input  logic [7:0] w_word0,
  input  logic [7:0] w_hi0,
  input  logic [7:0] w_lo0,
  input  logic [7:0] w_word1,
  input  logic [7:0] w_hi1,
  input  logic [7:0] w_lo1,
  input  logic       w_lock0,
  input  logic       w_lock1,
  output logic       w_gnt0,
  output logic       w_gnt1,
  output logic       w_done0,
  output logic       w_done1,
  output logic [7:0] w_result,
  output logic       w_cf_out,
  output logic [7:0] w_alu_word,
  output logic [7:0] w_alu_hi,
  output logic [7:0] w_alu_lo,
  input  logic [7:0] w_alu_out,
  input  logic       w_alu_cf
);

  localparam logic [3:0] OP_SLE = 4'b0111;
  localparam logic [3:0] OP_SGE = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t state;
  logic   last_id;
  logic   win_id;
  logic   sel_vld;
  logic   sel_id;

`ifdef ALU_ARB_LOCK_EN
  logic lock_vld;
  logic lock_id;
  logic owner_lock;
  logic owner_req;
  logic sel_lock;

  assign owner_lock = lock_id ? w_lock1 : w_lock0;
  assign owner_req  = lock_id ? w_req1  : w_req0;
`else
  logic unused_lock;
  assign unused_lock = w_lock0 ^ w_lock1;
`endif

  // Winner selection; a held lock overrides round-robin and may leave the ALU idle.
  always_comb begin
    sel_vld = w_req0 | w_req1;
    sel_id  = (w_req0 && w_req1) ? ~last_id : w_req1;
`ifdef ALU_ARB_LOCK_EN
    sel_lock = sel_id ? w_lock1 : w_lock0;
    if (lock_vld && owner_lock) begin
      sel_vld  = owner_req;
      sel_id   = lock_id;
      sel_lock = 1'b1;
    end
`endif
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state      <= S_IDLE;
      w_gnt0     <= 1'b0;
      w_gnt1     <= 1'b0;
      w_done0    <= 1'b0;
      w_done1    <= 1'b0;
      w_result   <= 8'h00;
      w_cf_out   <= 1'b0;
      w_alu_word <= 8'h00;
      w_alu_hi   <= 8'h00;
      w_alu_lo   <= 8'h00;
      last_id    <= 1'b1;
      win_id     <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_vld   <= 1'b0;
      lock_id    <= 1'b0;
`endif
    end else begin
      w_gnt0  <= 1'b0;
      w_gnt1  <= 1'b0;
      w_done0 <= 1'b0;
      w_done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            w_gnt0     <= ~sel_id;
            w_gnt1     <= sel_id;
            win_id     <= sel_id;
            last_id    <= sel_id;
            w_alu_word <= sel_id ? w_word1 : w_word0;
            w_alu_hi   <= sel_id ? w_hi1   : w_hi0;
            w_alu_lo   <= sel_id ? w_lo1   : w_lo0;
            state      <= S_ISSUE;
`ifdef ALU_ARB_LOCK_EN
            lock_vld   <= sel_lock;
            lock_id    <= sel_id;
`endif
          end else begin
            w_alu_word <= 8'h00;
            w_alu_hi   <= 8'h00;
            w_alu_lo   <= 8'h00;
`ifdef ALU_ARB_LOCK_EN
            if (lock_vld && !owner_lock) lock_vld <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          w_result <= w_alu_out;
          // Only compare opcodes own the flag; everything else leaves it alone.
          if (w_alu_word[7:4] == OP_SGE || w_alu_word[7:4] == OP_SLE)
            w_cf_out <= w_alu_cf;
          w_done0 <= ~win_id;
          w_done1 <= win_id;
          state   <= S_DONE;
        end
        S_DONE: begin
          w_alu_word <= 8'h00;
          w_alu_hi   <= 8'h00;
          w_alu_lo   <= 8'h00;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_alu_arbiter.sv
// Scoreboard bench for m_alu_arbiter: driver pushes expected grants/completions, negedge monitor checks them.
module tb_m_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [7:0] word0 = 8'h00, hi0 = 8'h00, lo0 = 8'h00;
  logic [7:0] word1 = 8'h00, hi1 = 8'h00, lo1 = 8'h00;
  logic       gnt0, gnt1, done0, done1, cf_out, alu_cf;
  logic [7:0] result, alu_word, alu_hi, alu_lo, alu_out;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       cf;
  } exp_t;

  int   gq[$];
  exp_t dq[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, last_gnt_cyc = -10;
  logic [7:0] hold_res = 8'h00;
  logic       hold_cf = 1'b0;

  // reference model state
  int m_last = 1;
  bit m_cf = 1'b0;
  int m_owner = -1;

  always #5 clk = ~clk;

  // ALU stub: returns {cf, result}; cf toggles on non-compare ops so stray flag updates show up.
  function automatic logic [8:0] alu_fn(input logic [7:0] w, input logic [7:0] h, input logic [7:0] l);
    logic [7:0] r;
    logic       c;
    c = ^(h ^ l);
    case (w[7:4])
      4'h4: r = h + l;
      4'h5: r = h - l;
      4'h6: r = h & l;
      4'h7: begin r = h - l; c = (h <= l); end
      4'h8: begin r = l - h; c = (h >= l); end
      default: r = h ^ l ^ w;
    endcase
    return {c, r};
  endfunction

  assign {alu_cf, alu_out} = alu_fn(alu_word, alu_hi, alu_lo);

  m_alu_arbiter dut (
    .w_clock(clk), .w_reset_n(rst_n),
    .w_req0(req0), .w_req1(req1),
    .w_word0(word0), .w_hi0(hi0), .w_lo0(lo0),
    .w_word1(word1), .w_hi1(hi1), .w_lo1(lo1),
    .w_lock0(lock0), .w_lock1(lock1),
    .w_gnt0(gnt0), .w_gnt1(gnt1), .w_done0(done0), .w_done1(done1),
    .w_result(result), .w_cf_out(cf_out),
    .w_alu_word(alu_word), .w_alu_hi(alu_hi), .w_alu_lo(alu_lo),
    .w_alu_out(alu_out), .w_alu_cf(alu_cf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Decide the winner from the request/lock rules and the previous grant.
  function automatic int model_pick(input bit r0, input bit r1, input bit k0, input bit k1);
    int w;
    w = -1;
`ifdef ALU_ARB_LOCK_EN
    if (m_owner >= 0 && ((m_owner == 0) ? k0 : k1)) begin
      if ((m_owner == 0) ? r0 : r1) w = m_owner;
    end else begin
      m_owner = -1;
      if (r0 && r1) w = 1 - m_last;
      else if (r0) w = 0;
      else if (r1) w = 1;
      if (w >= 0 && ((w == 0) ? k0 : k1)) m_owner = w;
    end
`else
    if (r0 && r1) w = 1 - m_last;
    else if (r0) w = 0;
    else if (r1) w = 1;
`endif
    if (w >= 0) m_last = w;
    return w;
  endfunction

  task automatic model_reset();
    m_last = 1;
    m_cf = 1'b0;
    m_owner = -1;
  endtask

  task automatic scramble();
    req0 = 1'($urandom); req1 = 1'($urandom);
    word0 = 8'($urandom); hi0 = 8'($urandom); lo0 = 8'($urandom);
    word1 = 8'($urandom); hi1 = 8'($urandom); lo1 = 8'($urandom);
  endtask

  // Called shortly after a rising edge with the DUT in IDLE; returns likewise.
  // abort=1 pulls reset during the ISSUE cycle instead of letting the op complete.
  task automatic op(input bit r0, input bit r1,
                    input logic [7:0] a0, input logic [7:0] h0, input logic [7:0] l0,
                    input logic [7:0] a1, input logic [7:0] h1, input logic [7:0] l1,
                    input bit k0, input bit k1, input bit abort);
    int         w;
    logic [8:0] f;
    exp_t       e;
    req0 = r0; req1 = r1; lock0 = k0; lock1 = k1;
    word0 = a0; hi0 = h0; lo0 = l0; word1 = a1; hi1 = h1; lo1 = l1;
    w = model_pick(r0, r1, k0, k1);
    if (w >= 0) begin
      gq.push_back(w);
      if (!abort) begin
        f = (w == 0) ? alu_fn(a0, h0, l0) : alu_fn(a1, h1, l1);
        if (((w == 0) ? a0[7:4] : a1[7:4]) inside {4'h7, 4'h8}) m_cf = f[8];
        e.id = w; e.res = f[7:0]; e.cf = m_cf;
        dq.push_back(e);
      end
    end
    @(posedge clk); #1;
    if (w < 0) return;
    scramble();
    if (abort) begin
      #5 rst_n = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      #1;
      chk("abort_result", result, 8'h00);
      chk("abort_cf", cf_out, 1'b0);
      chk("abort_done", {done0, done1}, 2'b00);
      return;
    end
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
  endtask

  // Monitor: grants and completions against the scoreboard, result/flag hold otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin hold_res = 8'h00; hold_cf = 1'b0; end
      if (gnt0 || gnt1) begin
        chk("gnt_onehot", {gnt0, gnt1} != 2'b11, 1);
        chk("gnt_expected", gq.size() != 0, 1);
        if (gq.size() != 0) chk("gnt_id", gnt1, gq.pop_front());
        last_gnt_cyc = cyc;
      end
      if (done0 || done1) begin
        chk("done_onehot", {done0, done1} != 2'b11, 1);
        chk("done_latency", cyc, last_gnt_cyc + 1);
        chk("done_expected", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          chk("done_id", done1, e.id);
          chk("result", result, e.res);
          chk("cf_out", cf_out, e.cf);
          hold_res = e.res;
          hold_cf = e.cf;
        end
      end else begin
        chk("result_hold", result, hold_res);
        chk("cf_hold", cf_out, hold_cf);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_gnt", {gnt0, gnt1}, 2'b00);
    chk("rst_done", {done0, done1}, 2'b00);
    chk("rst_result", result, 8'h00);
    chk("rst_cf", cf_out, 1'b0);
    chk("rst_alu", {alu_word, alu_hi, alu_lo}, 24'h0);

    // contention after reset: 0,1,0,1
    for (int i = 0; i < 4; i++)
      op(1, 1, 8'h41, 8'($urandom), 8'($urandom), 8'h52, 8'($urandom), 8'($urandom), 0, 0, 0);

    // single add
    op(1, 0, 8'h40, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    chk("add_idle_alu", {alu_word, alu_hi, alu_lo}, 24'h0);

    // compare flag sequence on requester 1
    op(0, 1, 8'h00, 8'h00, 8'h00, 8'h80, 8'h05, 8'h03, 0, 0, 0);
    op(0, 1, 8'h00, 8'h00, 8'h00, 8'h40, 8'h05, 8'h03, 0, 0, 0);
    op(0, 1, 8'h00, 8'h00, 8'h00, 8'h70, 8'h05, 8'h03, 0, 0, 0);

    // reset during ISSUE, then a normal op
    op(1, 0, 8'h40, 8'h22, 8'h11, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    op(1, 0, 8'h40, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    // lock0 held across three contended ops, then released
    do_reset();
    for (int i = 0; i < 3; i++)
      op(1, 1, 8'h40, 8'(i), 8'h10, 8'h50, 8'h33, 8'(i), 1, 0, 0);
    op(1, 1, 8'h40, 8'h07, 8'h10, 8'h50, 8'h33, 8'h01, 0, 0, 0);

    for (int i = 0; i < 300; i++)
      op(1'($urandom), 1'($urandom),
         8'($urandom), 8'($urandom), 8'($urandom),
         8'($urandom), 8'($urandom), 8'($urandom),
         ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 0);

    req0 = 1'b0; req1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("gq_drained", gq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/m_alu_arbiter.md
M_ALU_ARBITER -- requirements
Module: m_alu_arbiter

Interface
REQ-001 Parameter: none; widths fixed at 8-bit words and operands.
REQ-002 w_clock  in  1  sole clock; all state updates on rising edge.
REQ-003 w_reset_n  in  1  asynchronous, active-low reset.
REQ-004 w_req0 / w_req1  in  1  requester 0/1 operation request.
REQ-005 w_word0 / w_word1  in  8  requester instruction word; opcode in [7:4].
REQ-006 w_hi0, w_lo0 / w_hi1, w_lo1  in  8  requester high/low register operand values.
REQ-007 w_lock0 / w_lock1  in  1  requester lock request; used only under ALU_ARB_LOCK_EN.
REQ-008 w_gnt0 / w_gnt1  out  1  one-cycle grant pulse.
REQ-009 w_done0 / w_done1  out  1  one-cycle completion pulse; w_result valid in that cycle.
REQ-010 w_result  out  8  registered ALU result of the last completed operation.
REQ-011 w_cf_out  out  1  registered comparison flag.
REQ-012 w_alu_word, w_alu_hi, w_alu_lo  out  8 each  registered drive to ALU word/high/low inputs.
REQ-013 w_alu_out  in  8  ALU result; w_alu_cf  in  1  ALU comparison flag.

Function
REQ-014 FSM states IDLE, ISSUE, DONE; exactly one operation in flight.
REQ-015 Requests sampled only in IDLE; no request -> stay IDLE with w_alu_word/hi/lo = 8'h00.
REQ-016 IDLE with a request: winner's word/hi/lo registered onto w_alu_*, winner's gnt high for the following cycle, next state ISSUE.
REQ-017 ISSUE -> DONE unconditionally; at that edge w_result <= w_alu_out.
REQ-018 At the ISSUE->DONE edge, if w_alu_word[7:4] is 4'b1000 (sge) or 4'b0111 (sle), w_cf_out <= w_alu_cf; otherwise w_cf_out holds.
REQ-019 DONE: winner's done high for one cycle; w_alu_* hold; next state IDLE; w_alu_* return to 8'h00 in IDLE.
REQ-020 Latency: done asserts two cycles after the sampling edge; peak throughput one operation per 3 cycles.
REQ-021 Operands are latched at grant; requester may change word/hi/lo after gnt.
REQ-022 Request still high when IDLE is re-entered is a new request; requester deasserts req in the DONE cycle if no further operation is wanted.
REQ-023 Arbitration round-robin: single request -> granted; both -> grant the requester not granted last; last-granted pointer updates on each grant.
REQ-024 w_result and w_cf_out hold between operations; never change outside the ISSUE->DONE edge.
REQ-025 gnt0/gnt1 never both high; done0/done1 never both high.

Reset
REQ-026 w_reset_n low, any state: FSM IDLE; gnt, done, w_result, w_cf_out, w_alu_* all 0; last-granted pointer = 1, so requester 0 wins first contention.
REQ-027 Reset mid-operation: in-flight operation discarded; no done issued; w_cf_out cleared.
REQ-028 Release of reset needs no further initialisation; first request is sampled at the first rising edge after release.

Configuration
REQ-029 Macro ALU_ARB_LOCK_EN defined: a requester whose lock input is high at its grant edge owns the ALU; while the owner's lock stays high only that requester is granted, the other waits; lock takes effect at the owner's next IDLE sampling edge; round-robin resumes at the first IDLE sampling edge with owner lock low.
REQ-030 Macro ALU_ARB_LOCK_EN undefined: w_lock0/w_lock1 ignored; pure round-robin.

Verification
REQ-031 Single add: req0, word0=8'h40, hi0=8'h12, lo0=8'h34 -> gnt0 next cycle, done0 two cycles after the sampling edge, w_result=8'h46.
REQ-032 Contention after reset: req0 and req1 both held high -> grant order gnt0, gnt1, gnt0, gnt1.
REQ-033 Compare: req1, sge 8'h80, hi=8'h05, lo=8'h03 -> w_cf_out=1; then add op -> w_cf_out stays 1; then sle hi=8'h05, lo=8'h03 -> w_cf_out=0.
REQ-034 Reset mid-op: w_reset_n low during ISSUE -> no done pulse; w_result=8'h00, w_cf_out=0; a new req0 afterwards completes normally.
REQ-035 ALU_ARB_LOCK_EN defined: lock0 high, req0 and req1 high for three operations -> three consecutive gnt0, no gnt1; drop lock0 -> next grant gnt1.
REQ-036 ALU_ARB_LOCK_EN undefined, same stimulus as REQ-035 -> gnt alternates gnt0, gnt1.
